// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO register bank: output/direction registers, atomic set/clear/toggle,
// synchronised inputs and per-pin edge capture with a level interrupt.
module gpio_ctrl #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'd5000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             weIn,
  input  logic [31:0]      addrIn,
  input  logic [31:0]      dataIn,
  output logic [31:0]      dataOut,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  output logic             irq
);

  localparam logic [3:0] OFF_OUT  = 4'd0;
  localparam logic [3:0] OFF_DIR  = 4'd1;
  localparam logic [3:0] OFF_IN   = 4'd2;
  localparam logic [3:0] OFF_SET  = 4'd3;
  localparam logic [3:0] OFF_CLR  = 4'd4;
  localparam logic [3:0] OFF_TGL  = 4'd5;
  localparam logic [3:0] OFF_IE   = 4'd6;
  localparam logic [3:0] OFF_RISE = 4'd7;
  localparam logic [3:0] OFF_FALL = 4'd8;
  localparam logic [3:0] OFF_STAT = 4'd9;

  logic [31:0]      offset_s;
  logic             hit_s;
  logic [3:0]       regSel_s;
  logic [WIDTH-1:0] wrData_s;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] out_r, dir_r, ie_r, riseEn_r, fallEn_r, stat_r;
  logic [WIDTH-1:0] outNext_s, dirNext_s, ieNext_s, riseNext_s, fallNext_s, statNext_s;
  logic             irq_r;

  function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Full-address subtraction also wraps addresses below the base out of the window.
  assign offset_s = addrIn - BASE_ADDR;
  assign hit_s    = (offset_s < 32'd64);
  assign regSel_s = offset_s[5:2];
  assign wrData_s = dataIn[WIDTH-1:0];
  assign in_s     = sync_r[SYNC_STAGES-1];
  assign edge_s   = (in_s & ~prev_r & riseEn_r) | (~in_s & prev_r & fallEn_r);

  // Input synchroniser chain and previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= in_s;
    end
  end

  // Next-state decode for the writable registers; edge set takes priority over W1C.
  always_comb begin
    outNext_s  = out_r;
    dirNext_s  = dir_r;
    ieNext_s   = ie_r;
    riseNext_s = riseEn_r;
    fallNext_s = fallEn_r;
    statNext_s = stat_r | edge_s;
    if (weIn && hit_s) begin
      case (regSel_s)
        OFF_OUT:  outNext_s  = wrData_s;
        OFF_DIR:  dirNext_s  = wrData_s;
        OFF_SET:  outNext_s  = out_r | wrData_s;
        OFF_CLR:  outNext_s  = out_r & ~wrData_s;
        OFF_TGL:  outNext_s  = out_r ^ wrData_s;
        OFF_IE:   ieNext_s   = wrData_s;
        OFF_RISE: riseNext_s = wrData_s;
        OFF_FALL: fallNext_s = wrData_s;
        OFF_STAT: statNext_s = (stat_r & ~wrData_s) | edge_s;
        default:  outNext_s  = out_r;
      endcase
    end else begin
      outNext_s = out_r;
    end
  end

  // Register bank and registered interrupt level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_r    <= '0;
      dir_r    <= '0;
      ie_r     <= '0;
      riseEn_r <= '0;
      fallEn_r <= '0;
      stat_r   <= '0;
      irq_r    <= 1'b0;
    end else begin
      out_r    <= outNext_s;
      dir_r    <= dirNext_s;
      ie_r     <= ieNext_s;
      riseEn_r <= riseNext_s;
      fallEn_r <= fallNext_s;
      stat_r   <= statNext_s;
      irq_r    <= |(statNext_s & ieNext_s);
    end
  end

  // Combinational read mux; write-only and unmapped offsets read 0.
  always_comb begin
    dataOut = 32'd0;
    if (hit_s) begin
      case (regSel_s)
        OFF_OUT:  dataOut = widen(out_r);
        OFF_DIR:  dataOut = widen(dir_r);
        OFF_IN:   dataOut = widen(in_s);
        OFF_IE:   dataOut = widen(ie_r);
        OFF_RISE: dataOut = widen(riseEn_r);
        OFF_FALL: dataOut = widen(fallEn_r);
        OFF_STAT: dataOut = widen(stat_r);
        default:  dataOut = 32'd0;
      endcase
    end else begin
      dataOut = 32'd0;
    end
  end

  assign io_out = out_r;
  assign io_oe  = dir_r;
  assign irq    = irq_r;

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Memory-mapped, parametrised GPIO controller for the RISC-V SoC top level. It replaces the single write-only output latch at address 5000 with a full register bank:
- readable output register with per-pin direction control;
- atomic set/clear/toggle writes;
- synchronised inputs;
- per-pin rising/falling edge capture with a level interrupt to the core.

It sits on the CPU data bus beside Ram and decodes its own address window.

## Interface
- WIDTH, 32, number of GPIO pins (1..32); register bits at and above WIDTH read 0 and ignore writes.
- BASE_ADDR, 32'd5000, byte address of register offset 0x00; must be word aligned.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- weIn  in  1  bus write strobe from CPU.
- addrIn  in  32  bus byte address.
- dataIn  in  32  bus write data.
- dataOut  out  32  read data; combinational; 0 when addrIn is outside the window.
- io_in  in  WIDTH  asynchronous pin inputs.
- io_out  out  WIDTH  pin output values (= OUT).
- io_oe  out  WIDTH  pin output enables (= DIR, 1 = drive).
- irq  out  1  interrupt, level high = |(STAT & IE).

## Operation
- Decode: hit when addrIn[31:2] matches (BASE_ADDR + off)[31:2]; addrIn[1:0] ignored. Unmapped offsets in window 0x00–0x3C: read 0, writes ignored.
- Register map (offset, access, function):
  - 0x00 OUT, RW: output data.
  - 0x04 DIR, RW: 1 = output.
  - 0x08 IN, RO: synchronised pin state, last synchroniser stage.
  - 0x0C SET, WO: OUT |= data.
  - 0x10 CLR, WO: OUT &= ~data.
  - 0x14 TGL, WO: OUT ^= data.
  - 0x18 IE, RW: per-pin interrupt enable.
  - 0x1C RISE, RW: enable rising-edge capture.
  - 0x20 FALL, RW: enable falling-edge capture.
  - 0x24 STAT, R/W1C: captured edge flags.
  - Write-only registers (SET, CLR, TGL) read 0.
- Edge detect: `prev` holds the previous IN value. `rise = IN & ~prev & RISE`; `fall = ~IN & prev & FALL`. STAT bit is set when (rise | fall), independently of IE.
- STAT clear: writing 1 clears that bit; writing 0 leaves it unchanged.
- Simultaneous edge and W1C on the same bit in the same cycle: set wins, bit stays 1.
- irq is a level; it deasserts only when the enabled STAT bits are cleared or IE is cleared.
- Only one register is written per cycle, so SET/CLR/TGL cannot collide with each other.
- Reset (rst=0 at a clk edge) clears everything to 0, including mid-operation: OUT, DIR, IE, RISE, FALL, STAT, synchroniser stages and `prev`. Resulting outputs: io_out=0, io_oe=0, irq=0.

## Timing
- Register write: takes effect at the clk edge where weIn=1 and the address hits. io_out/io_oe reflect it immediately after that edge.
- Register read: combinational in the same cycle as addrIn, so the single-cycle CPU load completes without stalls.
- Input path: an io_in change that is stable before edge 1 appears in IN after edge SYNC_STAGES. The corresponding STAT bit and irq rise after edge SYNC_STAGES+1.
- Pulses shorter than one clk period may be missed. A pulse that is captured yields exactly one rise and one fall event.
- Input held high through reset release: `prev`=0 yields a rise event, but RISE=0 after reset, so it is not captured.
- No handshake: the bus is single-cycle write and combinational read.

## Test plan
- Reset: hold rst=0 for 2 cycles with io_in=all 1s. After release: io_out=0, io_oe=0, irq=0; every register reads 0 except IN, which reads 0xFFFFFFFF after 2 cycles.
- Output ops: write OUT=0x0000_00F0, then SET 0x0F, then CLR 0x30, then TGL 0x101. Read OUT = 0x0000_01CE; io_out tracks after each write edge.
- Direction/readback: write DIR=0xA5A5_A5A5. Read 0x04 returns the same value and io_oe matches. A write to IN (0x08) is ignored.
- Rising interrupt: RISE=0x1, IE=0x1, raise io_in[0] → STAT=0x1 and irq=1 exactly SYNC_STAGES+1 edges later. W1C 0x1 to STAT → irq=0 next cycle.
- Set-wins race: FALL=0x2, IE=0x2, arrange a falling edge on pin 1 in the same cycle as a W1C 0x2 → STAT[1] stays 1 and irq stays 1.
- Decode/width: with WIDTH=8, write OUT=0xFFFF_FFFF → read 0x0000_00FF. Access BASE_ADDR+0x40 and BASE_ADDR-4 → dataOut=0 and no state change.
